syscall_unit: RTL and testbench

Executes MIPS syscalls for the pipelined CPU. On a syscall it latches `v0` (service code) and `a0` (argument) from the register file and streams ASCII output to the console through a valid/ready byte port. Service 4 walks a null-terminated string in data memory over a request/acknowledge port. `stall` freezes the pipeline until the service completes; service 10 halts the machine.

---
 rtl/syscall_unit.sv | 215 +++++++++++++++++++++
 tb/tb_syscall_unit.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_unit.sv
// MIPS syscall service unit: print int/string/char, halt.
// Streams console bytes over valid/ready and walks strings in data memory.
module syscall_unit #(
    parameter int unsigned MAX_STR = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_syscall,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        halt,
    output logic        bad_code
);

    localparam int CW = $clog2(MAX_STR + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT_SIGN,
        S_INT_DIG,
        S_INT_EMIT,
        S_STR_REQ,
        S_STR_EMIT,
        S_CHR_EMIT,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     mag_q, mag_d;
    logic [3:0]      p_q, p_d;
    logic [3:0]      dig_q, dig_d;
    logic            started_q, started_d;
    logic [31:0]     addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            bad_q, bad_d;

    logic [31:0]     pw;
    logic [7:0]      sel_byte;
    logic [CW-1:0]   cnt_inc;

    function automatic logic [31:0] pow10(input logic [3:0] p);
        unique case (p)
            4'd9:    return 32'd1000000000;
            4'd8:    return 32'd100000000;
            4'd7:    return 32'd10000000;
            4'd6:    return 32'd1000000;
            4'd5:    return 32'd100000;
            4'd4:    return 32'd10000;
            4'd3:    return 32'd1000;
            4'd2:    return 32'd100;
            4'd1:    return 32'd10;
            default: return 32'd1;
        endcase
    endfunction

    assign pw      = pow10(p_q);
    assign cnt_inc = cnt_q + CW'(1);

    // Big-endian lane select within the fetched word
    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    sel_byte = mem_rdata[31:24];
            2'd1:    sel_byte = mem_rdata[23:16];
            2'd2:    sel_byte = mem_rdata[15:8];
            default: sel_byte = mem_rdata[7:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        p_d       = p_q;
        dig_d     = dig_q;
        started_d = started_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        bad_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (sig_syscall) begin
                    unique case (v0)
                        32'd1: begin
                            mag_d     = a0[31] ? (~a0 + 32'd1) : a0;
                            p_d       = 4'd9;
                            dig_d     = 4'd0;
                            started_d = 1'b0;
                            state_d   = a0[31] ? S_INT_SIGN : S_INT_DIG;
                        end
                        32'd4: begin
                            addr_d  = a0;
                            cnt_d   = '0;
                            state_d = S_STR_REQ;
                        end
                        32'd11: begin
                            byte_d  = a0[7:0];
                            state_d = S_CHR_EMIT;
                        end
                        32'd10:  state_d = S_HALT;
                        default: bad_d = 1'b1;
                    endcase
                end
            end
            S_INT_SIGN: begin
                if (char_ready) state_d = S_INT_DIG;
            end
            S_INT_DIG: begin
                if (mag_q >= pw) begin
                    mag_d = mag_q - pw;
                    dig_d = dig_q + 4'd1;
                end else if (dig_q != 4'd0 || started_q || p_q == 4'd0) begin
                    started_d = 1'b1;
                    state_d   = S_INT_EMIT;
                end else begin
                    p_d   = p_q - 4'd1;
                    dig_d = 4'd0;
                end
            end
            S_INT_EMIT: begin
                if (char_ready) begin
                    if (p_q == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        p_d     = p_q - 4'd1;
                        dig_d   = 4'd0;
                        state_d = S_INT_DIG;
                    end
                end
            end
            S_STR_REQ: begin
                if (mem_ack) begin
                    if (sel_byte == 8'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        byte_d  = sel_byte;
                        state_d = S_STR_EMIT;
                    end
                end
            end
            S_STR_EMIT: begin
                if (char_ready) begin
                    addr_d  = addr_q + 32'd1;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == CW'(MAX_STR)) ? S_IDLE : S_STR_REQ;
                end
            end
            S_CHR_EMIT: begin
                if (char_ready) state_d = S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mag_q     <= '0;
            p_q       <= '0;
            dig_q     <= '0;
            started_q <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            byte_q    <= '0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            p_q       <= p_d;
            dig_q     <= dig_d;
            started_q <= started_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            bad_q     <= bad_d;
        end
    end

    always_comb begin
        char_valid = 1'b0;
        char_data  = 8'd0;
        unique case (state_q)
            S_INT_SIGN: begin
                char_valid = 1'b1;
                char_data  = 8'h2D;
            end
            S_INT_EMIT: begin
                char_valid = 1'b1;
                char_data  = 8'h30 + {4'd0, dig_q};
            end
            S_STR_EMIT, S_CHR_EMIT: begin
                char_valid = 1'b1;
                char_data  = byte_q;
            end
            default: ;
        endcase
    end

    assign stall    = (state_q != S_IDLE) | sig_syscall;
    assign mem_req  = (state_q == S_STR_REQ);
    assign mem_addr = mem_req ? addr_q : 32'd0;
    assign halt     = (state_q == S_HALT);
    assign bad_code = bad_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Randomized self-checking bench for syscall_unit.
// Expected console text comes from $sformatf and a byte-addressed memory model.
module tb_syscall_unit;

    localparam int MAXS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_syscall = 1'b0;
    logic [31:0] v0 = '0;
    logic [31:0] a0 = '0;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready = 1'b0;
    logic        halt;
    logic        bad_code;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];
    logic [7:0]  got [$];
    logic [31:0] reqs [$];
    int          bad_seen = 0;
    int          ack_dly = 0;
    bit          rdy_rand = 1'b0;
    int          wcnt = 0;

    always #5 clk = ~clk;

    syscall_unit #(.MAX_STR(MAXS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sig_syscall(sig_syscall),
        .v0(v0),
        .a0(a0),
        .stall(stall),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .char_valid(char_valid),
        .char_data(char_data),
        .char_ready(char_ready),
        .halt(halt),
        .bad_code(bad_code)
    );

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        logic [31:0] k;
        logic [31:0] w;
        int sh;
        k  = {a[31:2], 2'b00};
        w  = mem.exists(k) ? mem[k] : 32'h0;
        sh = 24 - 8 * int'(a[1:0]);
        return 8'(w >> sh);
    endfunction

    task automatic wr_byte(input logic [31:0] a, input logic [7:0] b);
        logic [31:0] k;
        logic [31:0] w;
        int sh;
        k  = {a[31:2], 2'b00};
        w  = mem.exists(k) ? mem[k] : 32'h0;
        sh = 24 - 8 * int'(a[1:0]);
        w  = (w & ~(32'hFF << sh)) | (32'(b) << sh);
        mem[k] = w;
    endtask

    function automatic string got_str();
        string s;
        s = "";
        foreach (got[i]) s = $sformatf("%s%c", s, got[i]);
        return s;
    endfunction

    // Console sink and bad_code counter, sampled at the transfer edge
    always @(posedge clk) begin
        if (char_valid && char_ready) got.push_back(char_data);
        if (bad_code) bad_seen++;
    end

    // Memory responder and optional random console back-pressure
    always @(negedge clk) begin
        if (rdy_rand) char_ready = 1'($urandom_range(0, 1));
        mem_ack = 1'b0;
        if (!mem_req) begin
            wcnt = 0;
        end else if (wcnt >= ack_dly) begin
            mem_ack   = 1'b1;
            mem_rdata = mem.exists({mem_addr[31:2], 2'b00}) ?
                        mem[{mem_addr[31:2], 2'b00}] : 32'h0;
            reqs.push_back(mem_addr);
            wcnt = 0;
        end else begin
            wcnt++;
        end
    end

    task automatic do_start(input logic [31:0] v, input logic [31:0] a);
        @(negedge clk);
        v0 = v;
        a0 = a;
        sig_syscall = 1'b1;
        #1;
    endtask

    task automatic do_end();
        @(negedge clk);
        sig_syscall = 1'b0;
        #1;
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!stall) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({stall, mem_req, mem_addr, char_valid, char_data, halt, bad_code} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b req=%b addr=%h cv=%b cd=%h halt=%b bad=%b want all 0",
                     stall, mem_req, mem_addr, char_valid, char_data, halt, bad_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_int_neg305();
        bit to;
        rdy_rand = 1'b0;
        char_ready = 1'b1;
        got.delete();
        bad_seen = 0;
        do_start(32'd1, 32'hFFFFFECF);
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL int_stall_issue: got %b want 1", stall);
        end
        do_end();
        checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h2D) begin
            errors++;
            $display("FAIL int_sign_latency: valid=%b data=%h want 1/2d", char_valid, char_data);
        end
        wait_idle(to);
        checks++;
        if (to || got_str() != "-305") begin
            errors++;
            $display("FAIL int_neg305: got \"%s\" timeout=%b want \"-305\"", got_str(), to);
        end
        checks++;
        if (bad_seen != 0) begin
            errors++;
            $display("FAIL int_no_bad: got %0d pulses want 0", bad_seen);
        end
    endtask

    task automatic test_int_values();
        logic [31:0] vals [$];
        logic [31:0] val;
        string exp;
        bit to;
        vals = '{32'd0, 32'h80000000, 32'h7FFFFFFF, 32'd9, 32'd10,
                 32'd1000000000, 32'hFFFFFFFF, 32'd100};
        for (int i = 0; i < 20; i++) vals.push_back($urandom);
        for (int i = 0; i < 6; i++) vals.push_back(32'($urandom_range(0, 2000)) - 32'd1000);
        foreach (vals[i]) begin
            val = vals[i];
            rdy_rand = (i % 2 == 1);
            char_ready = 1'b1;
            got.delete();
            do_start(32'd1, val);
            do_end();
            wait_idle(to);
            rdy_rand = 1'b0;
            exp = $sformatf("%0d", $signed(val));
            checks++;
            if (to || got_str() != exp) begin
                errors++;
                $display("FAIL int_value %h: got \"%s\" timeout=%b want \"%s\"",
                         val, got_str(), to, exp);
            end
        end
    endtask

    task automatic test_str_directed();
        bit to;
        mem.delete();
        mem[32'h10010000] = 32'h00000048;
        mem[32'h10010004] = 32'h69000000;
        ack_dly = 2;
        rdy_rand = 1'b0;
        char_ready = 1'b1;
        reqs.delete();
        got.delete();
        do_start(32'd4, 32'h10010003);
        do_end();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10010003) begin
            errors++;
            $display("FAIL str_first_req: req=%b addr=%h want 1/10010003", mem_req, mem_addr);
        end
        wait_idle(to);
        checks++;
        if (to || reqs.size() != 3 || reqs[0] !== 32'h10010003 ||
            reqs[1] !== 32'h10010004 || reqs[2] !== 32'h10010005) begin
            errors++;
            $display("FAIL str_req_addrs: got %0d requests timeout=%b want 3 at 10010003..05",
                     reqs.size(), to);
        end
        checks++;
        if (got_str() != "Hi") begin
            errors++;
            $display("FAIL str_directed: got \"%s\" want \"Hi\"", got_str());
        end
    endtask

    task automatic test_str_random();
        logic [31:0] base;
        logic [7:0]  b;
        int len;
        int nreq;
        string exp;
        bit to;
        for (int it = 0; it < 14; it++) begin
            mem.delete();
            base = (it == 0) ? 32'hFFFFFFFA : $urandom;
            len = (it == 1) ? MAXS : (it == 2) ? MAXS + 5 : $urandom_range(0, MAXS + 6);
            for (int i = 0; i < len; i++) wr_byte(base + 32'(i), 8'($urandom_range(33, 126)));
            wr_byte(base + 32'(len), 8'h00);
            exp = "";
            nreq = 0;
            for (int i = 0; i < MAXS; i++) begin
                b = rd_byte(base + 32'(i));
                nreq++;
                if (b == 8'h00) break;
                exp = $sformatf("%s%c", exp, b);
            end
            ack_dly = $urandom_range(0, 3);
            rdy_rand = 1'b1;
            reqs.delete();
            got.delete();
            do_start(32'd4, base);
            do_end();
            wait_idle(to);
            rdy_rand = 1'b0;
            char_ready = 1'b1;
            checks++;
            if (to || got_str() != exp || reqs.size() != nreq) begin
                errors++;
                $display("FAIL str_random base=%h: got \"%s\" reqs=%0d timeout=%b want \"%s\" reqs=%0d",
                         base, got_str(), reqs.size(), to, exp, nreq);
            end
        end
    endtask

    task automatic test_char_hold();
        rdy_rand = 1'b0;
        char_ready = 1'b0;
        got.delete();
        do_start(32'd11, 32'h00000141);
        do_end();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (char_valid !== 1'b1 || char_data !== 8'h41 || stall !== 1'b1) begin
                errors++;
                $display("FAIL char_hold cycle %0d: valid=%b data=%h stall=%b want 1/41/1",
                         i, char_valid, char_data, stall);
            end
            @(negedge clk);
            #1;
        end
        char_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || char_valid !== 1'b0 || got.size() != 1 || got_str() != "A") begin
            errors++;
            $display("FAIL char_transfer: stall=%b valid=%b got \"%s\" want 0/0/\"A\"",
                     stall, char_valid, got_str());
        end
    endtask

    task automatic test_bad_code();
        logic [31:0] codes [$];
        logic [31:0] c;
        int sh;
        int bh;
        int vh;
        codes.push_back(32'd7);
        for (int i = 0; i < 4; i++) begin
            do c = $urandom; while (c == 1 || c == 4 || c == 10 || c == 11);
            codes.push_back(c);
        end
        codes.push_back(32'd0);
        foreach (codes[k]) begin
            sh = 0;
            bh = 0;
            vh = 0;
            do_start(codes[k], $urandom);
            for (int i = 0; i < 6; i++) begin
                sh += int'(stall);
                bh += int'(bad_code);
                vh += int'(char_valid);
                if (i == 0) do_end();
                else begin
                    @(negedge clk);
                    #1;
                end
            end
            checks++;
            if (sh != 1 || bh != 1 || vh != 0) begin
                errors++;
                $display("FAIL bad_code %h: stall_cycles=%0d bad_cycles=%0d valid_cycles=%0d want 1/1/0",
                         codes[k], sh, bh, vh);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit to;
        mem.delete();
        for (int i = 0; i < 8; i++) wr_byte(32'h2000 + 32'(i), 8'h41 + 8'(i));
        wr_byte(32'h2008, 8'h00);
        ack_dly = 0;
        rdy_rand = 1'b0;
        char_ready = 1'b0;
        got.delete();
        do_start(32'd4, 32'h2000);
        do_end();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (char_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rstmid_reach_emit: char_valid=%b want 1", char_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stall, mem_req, mem_addr, char_valid, char_data, halt, bad_code} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: stall=%b req=%b addr=%h cv=%b cd=%h halt=%b bad=%b want all 0",
                     stall, mem_req, mem_addr, char_valid, char_data, halt, bad_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (got.size() != 0) begin
            errors++;
            $display("FAIL rstmid_dropped: got %0d bytes want 0", got.size());
        end
        char_ready = 1'b1;
        do_start(32'd11, 32'h0000005A);
        do_end();
        wait_idle(to);
        checks++;
        if (to || got_str() != "Z") begin
            errors++;
            $display("FAIL rstmid_after: got \"%s\" timeout=%b want \"Z\"", got_str(), to);
        end
    endtask

    task automatic test_halt();
        int bad_cyc;
        rdy_rand = 1'b0;
        char_ready = 1'b1;
        got.delete();
        do_start(32'd10, 32'd0);
        do_end();
        bad_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                v0 = 32'd11;
                a0 = 32'h41;
                sig_syscall = 1'b1;
            end
            if (i == 51) sig_syscall = 1'b0;
            #1;
            if (halt !== 1'b1 || stall !== 1'b1 || char_valid !== 1'b0) bad_cyc++;
            @(negedge clk);
        end
        checks++;
        if (bad_cyc != 0 || got.size() != 0) begin
            errors++;
            $display("FAIL halt_hold: bad_cycles=%0d bytes=%0d want 0/0", bad_cyc, got.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (halt !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: halt=%b stall=%b want 0/0", halt, stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_int_neg305();
        test_int_values();
        test_str_directed();
        test_str_random();
        test_char_hold();
        test_bad_code();
        test_reset_mid();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
